// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver. It deframes 11-bit frames from the raw pins,
// checks start, stop and odd parity, and queues good bytes in a small FIFO.
module ps2_rx_fifo #(
    parameter int DEPTH_LOG2 = 3,
    parameter int TIMEOUT    = 50000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       nextdata_n,
    output logic [7:0] data,
    output logic       ready,
    output logic       overflow,
    output logic       frame_err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int TW    = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

    state_t                       state, state_nxt;
    logic [2:0]                   clk_sync, dat_sync;
    logic [10:0]                  frame;
    logic [3:0]                   bit_cnt;
    logic [TW-1:0]                idle_cnt;
    logic [DEPTH-1:0][7:0]        mem;
    logic [DEPTH_LOG2:0]          wr_ptr, rd_ptr;
    logic                         nd_q;

    logic fall, bit_in, timeout, in_check, good, empty, full, pop, push;

    // Falling edge seen between the two oldest clock stages. The device holds
    // data stable for microseconds around the edge, so the matching oldest
    // data stage is a safe sample point.
    assign fall     = clk_sync[2] & ~clk_sync[1];
    assign bit_in   = dat_sync[2];
    assign timeout  = (state == RECV) && (idle_cnt == TW'(TIMEOUT));
    assign in_check = (state == CHECK);
    // frame[0]=start, frame[8:1]=data LSB first, frame[9]=parity, frame[10]=stop
    assign good     = ~frame[0] & frame[10] & (^frame[9:1]);

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                   (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign pop   = nd_q & ~nextdata_n & ~empty;
    // A pop in the CHECK cycle frees a slot, so a full FIFO still accepts.
    assign push  = in_check & good & (~full | pop);

    assign data  = mem[rd_ptr[DEPTH_LOG2-1:0]];
    assign ready = ~empty;

    // Three-flop synchronisers for the asynchronous PS/2 pins.
    always_ff @(posedge clk) begin
        if (clrn) begin
            clk_sync <= '0;
            dat_sync <= '0;
        end else begin
            clk_sync <= {clk_sync[1:0], ps2_clk};
            dat_sync <= {dat_sync[1:0], ps2_data};
        end
    end

    // Receive state register.
    always_ff @(posedge clk) begin
        if (clrn) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state: start bit opens a frame, 11th edge closes it, timeout aborts.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (fall) state_nxt = RECV;
            RECV: begin
                if (timeout)                    state_nxt = IDLE;
                else if (fall && bit_cnt == 4'd10) state_nxt = CHECK;
            end
            CHECK:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Shift bits in LSB first; after 11 shifts the start bit sits at frame[0].
    always_ff @(posedge clk) begin
        if (clrn) begin
            frame   <= '0;
            bit_cnt <= '0;
        end else if (state == IDLE && fall) begin
            frame   <= {bit_in, frame[10:1]};
            bit_cnt <= 4'd1;
        end else if (state == RECV && fall && !timeout) begin
            frame   <= {bit_in, frame[10:1]};
            bit_cnt <= bit_cnt + 4'd1;
        end else if (state != RECV) begin
            bit_cnt <= '0;
        end
    end

    // Idle counter: runs only mid-frame, cleared by every falling edge.
    always_ff @(posedge clk) begin
        if (clrn)                                 idle_cnt <= '0;
        else if (state == RECV && !fall && !timeout) idle_cnt <= idle_cnt + 1'b1;
        else                                      idle_cnt <= '0;
    end

    // FIFO storage, pointers and the registered pop strobe.
    always_ff @(posedge clk) begin
        if (clrn) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            nd_q   <= 1'b1;
        end else begin
            nd_q <= nextdata_n;
            if (push) begin
                mem[wr_ptr[DEPTH_LOG2-1:0]] <= frame[8:1];
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (clrn) begin
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (in_check && good && full && !pop) overflow <= 1'b1;
            if ((in_check && !good) || timeout)   frame_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Bench for ps2_rx_fifo: directed scenarios plus random frames, compared each
// cycle against a queue-based model of the receiver and FIFO.
module tb_ps2_rx_fifo;

    localparam int TO = 300;

    logic       clk, clrn, ps2_clk, ps2_data, nextdata_n;
    logic [7:0] data;
    logic       ready, overflow, frame_err;

    ps2_rx_fifo #(.DEPTH_LOG2(3), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .clrn       (clrn),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .nextdata_n (nextdata_n),
        .data       (data),
        .ready      (ready),
        .overflow   (overflow),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] model_q[$];
    bit         m_ovf, m_ferr;
    bit         settle, checking;
    int         vectors, errs;
    event       fell11;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Model: frame rules applied to a plain queue.
    task automatic model_frame(input logic [10:0] f);
        if (f[0] == 1'b0 && f[10] == 1'b1 && (^f[9:1]) == 1'b1) begin
            if (model_q.size() < 8) model_q.push_back(f[8:1]);
            else                    m_ovf = 1'b1;
        end else begin
            m_ferr = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par_err,
                              input logic start_bit, input logic stop_bit);
        logic [10:0] f;
        f = {stop_bit, (~^b) ^ par_err, b, start_bit};
        for (int i = 0; i < 11; i++) begin
            ps2_data = f[i];
            tick(5);
            if (i == 10) settle = 1'b1;
            ps2_clk = 1'b0;
            if (i == 10) -> fell11;
            tick(10);
            ps2_clk = 1'b1;
            if (i == 10) begin
                model_frame(f);
                settle = 1'b0;
            end
            tick(5);
        end
    endtask

    task automatic do_pop();
        nextdata_n = 1'b0;
        tick(1);
        if (model_q.size() != 0) void'(model_q.pop_front());
        nextdata_n = 1'b1;
        tick(1);
    endtask

    task automatic do_reset();
        settle = 1'b1;
        clrn = 1'b1;
        tick(3);
        clrn = 1'b0;
        model_q.delete();
        m_ovf  = 1'b0;
        m_ferr = 1'b0;
        tick(1);
        settle = 1'b0;
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (checking && !settle) begin
            chk("ready", ready, 8'(model_q.size() != 0));
            if (model_q.size() != 0) chk("data", data, model_q[0]);
            chk("overflow", overflow, 8'(m_ovf));
            chk("frame_err", frame_err, 8'(m_ferr));
        end
    end

    initial begin
        vectors = 0; errs = 0; settle = 1'b0; checking = 1'b0;
        m_ovf = 1'b0; m_ferr = 1'b0;
        clrn = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; nextdata_n = 1'b1;
        tick(3);
        clrn = 1'b0;
        tick(1);
        chk("rst_ready", ready, 8'h00);
        chk("rst_data", data, 8'h00);
        chk("rst_overflow", overflow, 8'h00);
        chk("rst_frame_err", frame_err, 8'h00);
        checking = 1'b1;

        // Single byte: visible within 5 clk of the 11th edge.
        fork
            send_frame(8'h1C, 1'b0, 1'b0, 1'b1);
            begin
                @(fell11);
                tick(5);
                chk("single_ready", ready, 8'h01);
                chk("single_data", data, 8'h1C);
            end
        join
        tick(20);
        do_pop();

        // Held pop: one pop only.
        send_frame(8'hF0, 1'b0, 1'b0, 1'b1);
        send_frame(8'h1C, 1'b0, 1'b0, 1'b1);
        nextdata_n = 1'b0;
        tick(1);
        if (model_q.size() != 0) void'(model_q.pop_front());
        tick(99);
        chk("held_data", data, 8'h1C);
        chk("held_ready", ready, 8'h01);
        nextdata_n = 1'b1;
        tick(1);
        do_pop();
        chk("held_empty", ready, 8'h00);

        // Overflow: ninth byte dropped.
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b1);
        chk("ovf_flag", overflow, 8'h01);
        for (int i = 1; i <= 8; i++) begin
            chk("ovf_order", data, 8'(i));
            do_pop();
        end
        chk("ovf_drained", ready, 8'h00);

        // Parity error then a good byte.
        do_reset();
        send_frame(8'h1C, 1'b1, 1'b0, 1'b1);
        chk("par_ready", ready, 8'h00);
        chk("par_ferr", frame_err, 8'h01);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
        chk("par_next", data, 8'h5A);
        do_pop();

        // Timeout: 5 bits, silence, then a full frame.
        do_reset();
        settle = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ps2_data = (i == 0) ? 1'b0 : 1'b1;
            tick(5);
            ps2_clk = 1'b0;
            tick(10);
            ps2_clk = 1'b1;
            tick(5);
        end
        tick(TO + 10);
        m_ferr = 1'b1;
        settle = 1'b0;
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
        chk("to_ferr", frame_err, 8'h01);
        chk("to_data", data, 8'h5A);
        do_pop();
        chk("to_only", ready, 8'h00);

        // Full FIFO with a pop landing in the CHECK cycle of 0x77.
        do_reset();
        for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), 1'b0, 1'b0, 1'b1);
        fork
            send_frame(8'h77, 1'b0, 1'b0, 1'b1);
            begin
                @(fell11);
                tick(3);
                nextdata_n = 1'b0;
                tick(1);
                if (model_q.size() != 0) void'(model_q.pop_front());
                nextdata_n = 1'b1;
            end
        join
        tick(5);
        chk("chkpop_ovf", overflow, 8'h00);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) chk("chkpop_last", data, 8'h77);
            do_pop();
        end
        do_pop();
        chk("empty_pop", ready, 8'h00);
        send_frame(8'h33, 1'b0, 1'b0, 1'b1);
        chk("after_empty_pop", data, 8'h33);

        // Random frames, errors and pops.
        do_reset();
        for (int n = 0; n < 40; n++) begin
            send_frame(8'($urandom_range(0, 255)),
                       1'($urandom_range(0, 6) == 0),
                       1'($urandom_range(0, 19) == 0),
                       1'($urandom_range(0, 19) != 0));
            tick($urandom_range(1, 8));
            for (int p = $urandom_range(0, 2); p > 0; p--) do_pop();
        end

        tick(10);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
